// File: rtl/avg_frame_sched.sv
// Frame-level controller for the AVG vector core: go/reset pulse timing,
// halt watchdog and an edge-captured segment FIFO feeding the rasterizer.
module avg_frame_sched #(
    parameter int FIFO_DEPTH  = 16,
    parameter int GO_HOLD     = 16,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cpu_vggo_in,
    input  logic        cpu_vgrst_in,
    input  logic        avg_halt_in,
    input  logic        avg_lr_write_in,
    input  logic [12:0] seg_start_x_in,
    input  logic [12:0] seg_start_y_in,
    input  logic [12:0] seg_end_x_in,
    input  logic [12:0] seg_end_y_in,
    input  logic [3:0]  seg_intensity_in,
    output logic        avg_vggo_out,
    output logic        avg_rst_out,
    output logic        seg_valid_out,
    input  logic        seg_ready_in,
    output logic [55:0] seg_data_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic        overflow_out,
    output logic [7:0]  drop_count_out,
    output logic        timeout_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = (GO_HOLD > 1) ? $clog2(GO_HOLD) : 1;
    localparam logic [AW:0]   PTR_ZERO   = (AW+1)'(0);
    localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_ZERO  = HW'(0);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(GO_HOLD - 1);
    localparam logic [19:0]   WDOG_LIMIT = 20'(WDOG_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_KICK       = 3'd1,
        S_WAIT_START = 3'd2,
        S_RUN        = 3'd3,
        S_DRAIN      = 3'd4,
        S_RECOVER    = 3'd5
    } state_t;

    function automatic logic [55:0] pack_seg(
        input logic [3:0]  intensity,
        input logic [12:0] sx,
        input logic [12:0] sy,
        input logic [12:0] ex,
        input logic [12:0] ey
    );
        return {intensity, sx, sy, ex, ey};
    endfunction

    state_t        state_r, state_nxt_s;
    logic [HW-1:0] hold_r, hold_nxt_s;
    logic [19:0]   wdog_r, wdog_nxt_s;
    logic          go_pending_r, go_pending_nxt_s;
    logic          timeout_r, timeout_nxt_s;
    logic          overflow_r;
    logic [7:0]    drop_r;
    logic          vggo_r, rst_r, busy_r, frame_done_r;
    logic          lr_prev_r;
    logic          go_start_s, wdog_fire_s, vgrst_any_s;

    logic [55:0]   mem_r [FIFO_DEPTH];
    logic [AW:0]   wptr_r, rptr_r, count_s, count_after_s;
    logic          empty_s, full_s, push_s, pop_s, push_ok_s, drop_s, flush_s;
    logic [55:0]   seg_in_s;

    assign seg_in_s    = pack_seg(seg_intensity_in, seg_start_x_in, seg_start_y_in,
                                  seg_end_x_in, seg_end_y_in);
    assign count_s     = wptr_r - rptr_r;
    assign empty_s     = (count_s == PTR_ZERO);
    assign full_s      = (count_s == DEPTH_CNT);
    assign push_s      = avg_lr_write_in && !lr_prev_r && ((state_r == S_RUN) || (state_r == S_DRAIN));
    assign pop_s       = !empty_s && seg_ready_in;
    assign push_ok_s   = push_s && (!full_s || pop_s);
    assign flush_s     = (state_nxt_s == S_RECOVER);
    assign drop_s      = push_s && full_s && !pop_s && !flush_s;
    assign count_after_s = count_s + (push_ok_s ? PTR_ONE : PTR_ZERO) - (pop_s ? PTR_ONE : PTR_ZERO);

    assign wdog_fire_s = (wdog_r >= WDOG_LIMIT) && ((state_r == S_WAIT_START) || (state_r == S_RUN));
    assign vgrst_any_s = cpu_vgrst_in && (state_r != S_RECOVER);

    // Next-state, pending-go, timeout and timer update logic.
    always_comb begin
        state_nxt_s      = state_r;
        go_pending_nxt_s = go_pending_r | cpu_vggo_in;
        timeout_nxt_s    = timeout_r;
        go_start_s       = 1'b0;
        hold_nxt_s       = hold_r;
        wdog_nxt_s       = wdog_r;

        if (vgrst_any_s) begin
            // A coincident watchdog expiry keeps timeout set.
            state_nxt_s   = S_RECOVER;
            timeout_nxt_s = wdog_fire_s;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cpu_vggo_in || go_pending_r) begin
                        state_nxt_s      = S_KICK;
                        go_start_s       = 1'b1;
                        go_pending_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_KICK: begin
                    if (hold_r == HOLD_LAST) state_nxt_s = S_WAIT_START;
                    else                     state_nxt_s = S_KICK;
                end
                S_WAIT_START: begin
                    if (wdog_fire_s) begin
                        state_nxt_s   = S_RECOVER;
                        timeout_nxt_s = 1'b1;
                    end else if (!avg_halt_in) begin
                        state_nxt_s = S_RUN;
                    end else begin
                        state_nxt_s = S_WAIT_START;
                    end
                end
                S_RUN: begin
                    if (wdog_fire_s) begin
                        state_nxt_s   = S_RECOVER;
                        timeout_nxt_s = 1'b1;
                    end else if (avg_halt_in) begin
                        state_nxt_s = S_DRAIN;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (count_after_s == PTR_ZERO) state_nxt_s = S_IDLE;
                    else                           state_nxt_s = S_DRAIN;
                end
                S_RECOVER: begin
                    if (!cpu_vgrst_in && (hold_r == HOLD_LAST)) state_nxt_s = S_IDLE;
                    else                                        state_nxt_s = S_RECOVER;
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end

        if ((state_nxt_s != state_r) || ((state_r == S_RECOVER) && cpu_vgrst_in)) begin
            hold_nxt_s = HOLD_ZERO;
        end else if ((state_r == S_KICK) || (state_r == S_RECOVER)) begin
            hold_nxt_s = hold_r + HOLD_ONE;
        end else begin
            hold_nxt_s = hold_r;
        end

        if (go_start_s) begin
            wdog_nxt_s = 20'd0;
        end else if (((state_r == S_KICK) || (state_r == S_WAIT_START) || (state_r == S_RUN))
                     && (wdog_r != 20'hFFFFF)) begin
            wdog_nxt_s = wdog_r + 20'd1;
        end else begin
            wdog_nxt_s = wdog_r;
        end
    end

    // Control state, timers and registered status outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r      <= S_IDLE;
            hold_r       <= HOLD_ZERO;
            wdog_r       <= 20'd0;
            go_pending_r <= 1'b0;
            timeout_r    <= 1'b0;
            overflow_r   <= 1'b0;
            drop_r       <= 8'd0;
            vggo_r       <= 1'b0;
            rst_r        <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            lr_prev_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            hold_r       <= hold_nxt_s;
            wdog_r       <= wdog_nxt_s;
            go_pending_r <= go_pending_nxt_s;
            timeout_r    <= timeout_nxt_s;
            vggo_r       <= (state_nxt_s == S_KICK);
            rst_r        <= (state_nxt_s == S_RECOVER);
            busy_r       <= (state_nxt_s != S_IDLE);
            frame_done_r <= (state_r == S_DRAIN) && (state_nxt_s == S_IDLE);
            lr_prev_r    <= avg_lr_write_in;
            if (go_start_s) begin
                overflow_r <= 1'b0;
                drop_r     <= 8'd0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
                drop_r     <= (drop_r == 8'hFF) ? 8'hFF : (drop_r + 8'd1);
            end
        end
    end

    // FIFO pointers; entering RECOVER discards every queued segment.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
        end else if (flush_s) begin
            rptr_r <= wptr_r;
        end else begin
            if (push_ok_s) wptr_r <= wptr_r + PTR_ONE;
            if (pop_s)     rptr_r <= rptr_r + PTR_ONE;
        end
    end

    // Segment storage; contents are only observable through valid entries.
    always_ff @(posedge clk_in) begin
        if (push_ok_s && !flush_s) mem_r[wptr_r[AW-1:0]] <= seg_in_s;
    end

    assign seg_valid_out  = !empty_s;
    assign seg_data_out   = empty_s ? 56'd0 : mem_r[rptr_r[AW-1:0]];
    assign avg_vggo_out   = vggo_r;
    assign avg_rst_out    = rst_r;
    assign busy_out       = busy_r;
    assign frame_done_out = frame_done_r;
    assign overflow_out   = overflow_r;
    assign drop_count_out = drop_r;
    assign timeout_out    = timeout_r;

endmodule

// File: tb/tb_avg_frame_sched.sv
// Directed bench for avg_frame_sched (FIFO_DEPTH=4, GO_HOLD=16, WDOG_CYCLES=100).
module tb_avg_frame_sched;

    logic        clk_in = 1'b0;
    logic        rst_n_in, cpu_vggo_in, cpu_vgrst_in, avg_halt_in, avg_lr_write_in;
    logic [12:0] seg_start_x_in, seg_start_y_in, seg_end_x_in, seg_end_y_in;
    logic [3:0]  seg_intensity_in;
    logic        avg_vggo_out, avg_rst_out, seg_valid_out, seg_ready_in;
    logic [55:0] seg_data_out;
    logic        busy_out, frame_done_out, overflow_out, timeout_out;
    logic [7:0]  drop_count_out;

    int checks = 0;
    int errors = 0;
    int n;
    logic [55:0] popped[$];

    avg_frame_sched #(.FIFO_DEPTH(4), .GO_HOLD(16), .WDOG_CYCLES(100)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .cpu_vggo_in(cpu_vggo_in),
        .cpu_vgrst_in(cpu_vgrst_in), .avg_halt_in(avg_halt_in),
        .avg_lr_write_in(avg_lr_write_in), .seg_start_x_in(seg_start_x_in),
        .seg_start_y_in(seg_start_y_in), .seg_end_x_in(seg_end_x_in),
        .seg_end_y_in(seg_end_y_in), .seg_intensity_in(seg_intensity_in),
        .avg_vggo_out(avg_vggo_out), .avg_rst_out(avg_rst_out),
        .seg_valid_out(seg_valid_out), .seg_ready_in(seg_ready_in),
        .seg_data_out(seg_data_out), .busy_out(busy_out),
        .frame_done_out(frame_done_out), .overflow_out(overflow_out),
        .drop_count_out(drop_count_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // Record every accepted segment, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (rst_n_in === 1'b1 && seg_valid_out === 1'b1 && seg_ready_in === 1'b1)
            popped.push_back(seg_data_out);
    end

    function automatic logic [55:0] exp_seg(input int i);
        logic [3:0]  it;
        logic [12:0] sx, sy, ex, ey;
        it = 4'(i + 1);
        sx = 13'(37 * i + 5);
        sy = 13'(8000 - 11 * i);
        ex = 13'(1024 + 3 * i);
        ey = 13'(i * 257);
        return {it, sx, sy, ex, ey};
    endfunction

    task automatic set_seg(input int i);
        seg_intensity_in = 4'(i + 1);
        seg_start_x_in   = 13'(37 * i + 5);
        seg_start_y_in   = 13'(8000 - 11 * i);
        seg_end_x_in     = 13'(1024 + 3 * i);
        seg_end_y_in     = 13'(i * 257);
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_popped(input string tag, input int base, input int cnt);
        check({tag, "_count"}, 64'(popped.size()), 64'(cnt));
        for (int k = 0; k < cnt; k++)
            check(tag, (k < popped.size()) ? 64'(popped[k]) : {64{1'bx}}, 64'(exp_seg(base + k)));
    endtask

    initial begin
        rst_n_in = 1'b0; cpu_vggo_in = 1'b0; cpu_vgrst_in = 1'b0; avg_halt_in = 1'b1;
        avg_lr_write_in = 1'b0; seg_ready_in = 1'b1; set_seg(0);
        step(2);
        check("rst_vggo", 64'(avg_vggo_out), 64'd0);
        check("rst_avgrst", 64'(avg_rst_out), 64'd0);
        check("rst_valid", 64'(seg_valid_out), 64'd0);
        check("rst_data", 64'(seg_data_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_done", 64'(frame_done_out), 64'd0);
        check("rst_ovf", 64'(overflow_out), 64'd0);
        check("rst_drop", 64'(drop_count_out), 64'd0);
        check("rst_timeout", 64'(timeout_out), 64'd0);
        rst_n_in = 1'b1;
        step(1);

        // Normal frame: three 16-cycle line writes, ready held high.
        popped.delete();
        cpu_vggo_in = 1'b1; step(1); cpu_vggo_in = 1'b0;
        check("nf_busy", 64'(busy_out), 64'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (avg_vggo_out === 1'b1) n++;
            step(1);
        end
        check("nf_vggo_len", 64'(n), 64'd16);
        avg_halt_in = 1'b0; step(1);
        for (int s = 0; s < 3; s++) begin
            set_seg(s); avg_lr_write_in = 1'b1; step(1);
            check("nf_seg_valid", 64'(seg_valid_out), 64'd1);
            check("nf_seg_data", 64'(seg_data_out), 64'(exp_seg(s)));
            step(1);
            check("nf_seg_popped", 64'(seg_valid_out), 64'd0);
            step(14); avg_lr_write_in = 1'b0; step(4);
        end
        avg_halt_in = 1'b1; step(1);
        check("nf_drain_busy", 64'(busy_out), 64'd1);
        check("nf_drain_done", 64'(frame_done_out), 64'd0);
        step(1);
        check("nf_done", 64'(frame_done_out), 64'd1);
        check("nf_idle", 64'(busy_out), 64'd0);
        step(1);
        check("nf_done_pulse", 64'(frame_done_out), 64'd0);
        check_popped("nf_order", 0, 3);

        // Overflow: ready low, seven segments into four entries.
        popped.delete();
        seg_ready_in = 1'b0;
        cpu_vggo_in = 1'b1; step(1); cpu_vggo_in = 1'b0;
        step(16); avg_halt_in = 1'b0; step(1);
        for (int s = 0; s < 7; s++) begin
            if (s == 4) begin
                check("ov_full_no_ovf", 64'(overflow_out), 64'd0);
                check("ov_full_no_drop", 64'(drop_count_out), 64'd0);
            end
            set_seg(10 + s); avg_lr_write_in = 1'b1; step(2); avg_lr_write_in = 1'b0; step(2);
        end
        check("ov_flag", 64'(overflow_out), 64'd1);
        check("ov_drops", 64'(drop_count_out), 64'd3);
        avg_halt_in = 1'b1; step(5);
        check("ov_drain_hold", 64'(busy_out), 64'd1);
        check("ov_head_stable", 64'(seg_data_out), 64'(exp_seg(10)));
        seg_ready_in = 1'b1; step(3);
        check("ov_not_done", 64'(frame_done_out), 64'd0);
        check("ov_last_head", 64'(seg_data_out), 64'(exp_seg(13)));
        step(1);
        check("ov_done", 64'(frame_done_out), 64'd1);
        check("ov_empty", 64'(seg_valid_out), 64'd0);
        check_popped("ov_order", 10, 4);

        // Next go clears overflow; this frame then runs into the watchdog.
        seg_ready_in = 1'b0;
        cpu_vggo_in = 1'b1; step(1); cpu_vggo_in = 1'b0;
        check("go_clr_ovf", 64'(overflow_out), 64'd0);
        check("go_clr_drop", 64'(drop_count_out), 64'd0);
        step(16); avg_halt_in = 1'b0; step(4);
        set_seg(20); avg_lr_write_in = 1'b1; step(2); avg_lr_write_in = 1'b0; step(2);
        set_seg(21); avg_lr_write_in = 1'b1; step(2); avg_lr_write_in = 1'b0;
        check("wd_queued", 64'(seg_valid_out), 64'd1);
        step(74);
        check("wd_pre_rst", 64'(avg_rst_out), 64'd0);
        check("wd_pre_timeout", 64'(timeout_out), 64'd0);
        step(1);
        check("wd_rst", 64'(avg_rst_out), 64'd1);
        check("wd_timeout", 64'(timeout_out), 64'd1);
        check("wd_flush", 64'(seg_valid_out), 64'd0);
        avg_halt_in = 1'b1;
        step(15);
        check("wd_rst_hold", 64'(avg_rst_out), 64'd1);
        step(1);
        check("wd_rst_end", 64'(avg_rst_out), 64'd0);
        check("wd_idle", 64'(busy_out), 64'd0);
        check("wd_sticky", 64'(timeout_out), 64'd1);

        // vgrst and vggo together in IDLE: reset first, then the go.
        seg_ready_in = 1'b1;
        cpu_vgrst_in = 1'b1; cpu_vggo_in = 1'b1; step(1);
        cpu_vgrst_in = 1'b0; cpu_vggo_in = 1'b0;
        check("ri_rst", 64'(avg_rst_out), 64'd1);
        check("ri_vggo", 64'(avg_vggo_out), 64'd0);
        check("ri_timeout_clr", 64'(timeout_out), 64'd0);
        step(5); cpu_vgrst_in = 1'b1; step(1); cpu_vgrst_in = 1'b0;
        step(15);
        check("ri_rst_restart", 64'(avg_rst_out), 64'd1);
        step(1);
        check("ri_rst_end", 64'(avg_rst_out), 64'd0);
        check("ri_idle_gap", 64'(busy_out), 64'd0);
        step(1);
        check("ri_kick", 64'(avg_vggo_out), 64'd1);

        // Three go pulses during RUN merge into one extra frame.
        step(16); avg_halt_in = 1'b0; step(4);
        for (int p = 0; p < 3; p++) begin
            cpu_vggo_in = 1'b1; step(1); cpu_vggo_in = 1'b0; step(1);
        end
        step(8); avg_halt_in = 1'b1; step(2);
        check("gb_done", 64'(frame_done_out), 64'd1);
        check("gb_idle", 64'(busy_out), 64'd0);
        step(1);
        check("gb_extra_kick", 64'(avg_vggo_out), 64'd1);
        step(16); avg_halt_in = 1'b0; step(4); avg_halt_in = 1'b1; step(2);
        check("gb_extra_done", 64'(frame_done_out), 64'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (avg_vggo_out === 1'b1 || busy_out === 1'b1) n++;
            step(1);
        end
        check("gb_no_third", 64'(n), 64'd0);

        // rst_n low during RUN with two segments queued.
        popped.delete();
        seg_ready_in = 1'b0;
        cpu_vggo_in = 1'b1; step(1); cpu_vggo_in = 1'b0;
        step(16); avg_halt_in = 1'b0; step(2);
        set_seg(30); avg_lr_write_in = 1'b1; step(2); avg_lr_write_in = 1'b0; step(2);
        set_seg(31); avg_lr_write_in = 1'b1; step(2); avg_lr_write_in = 1'b0; step(1);
        check("rr_queued", 64'(seg_valid_out), 64'd1);
        check("rr_head", 64'(seg_data_out), 64'(exp_seg(30)));
        rst_n_in = 1'b0; step(1);
        check("rr_valid", 64'(seg_valid_out), 64'd0);
        check("rr_data", 64'(seg_data_out), 64'd0);
        check("rr_busy", 64'(busy_out), 64'd0);
        check("rr_vggo", 64'(avg_vggo_out), 64'd0);
        rst_n_in = 1'b1; avg_halt_in = 1'b1; step(3);
        check("rr_stays_idle", 64'(busy_out), 64'd0);

        // Full FIFO with push and pop in the same cycle.
        popped.delete();
        cpu_vggo_in = 1'b1; step(1); cpu_vggo_in = 1'b0;
        step(16); avg_halt_in = 1'b0; step(1);
        for (int s = 0; s < 4; s++) begin
            set_seg(40 + s); avg_lr_write_in = 1'b1; step(2); avg_lr_write_in = 1'b0; step(2);
        end
        check("fp_full_head", 64'(seg_data_out), 64'(exp_seg(40)));
        set_seg(44); avg_lr_write_in = 1'b1; seg_ready_in = 1'b1; step(1);
        seg_ready_in = 1'b0;
        check("fp_no_drop", 64'(drop_count_out), 64'd0);
        check("fp_no_ovf", 64'(overflow_out), 64'd0);
        check("fp_new_head", 64'(seg_data_out), 64'(exp_seg(41)));
        step(2); avg_lr_write_in = 1'b0; seg_ready_in = 1'b1; step(5);
        check("fp_empty", 64'(seg_valid_out), 64'd0);
        avg_halt_in = 1'b1; step(2);
        check("fp_done", 64'(frame_done_out), 64'd1);
        check_popped("fp_order", 40, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
